// File: rtl/scr1_tapc_dr_bank.sv
// Bank of JTAG TAP data registers: per-channel capture/shift and update registers,
// with a shift-length tracker that can veto updates after a malformed DR scan.
module scr1_tapc_dr_bank #(
  parameter int                    SCR1_DR_NUM      = 4,
  parameter int                    SCR1_WIDTH       = 32,
  parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE = '0,
  parameter bit                    SCR1_STRICT_LEN  = 1'b1,
  localparam int                   SEL_W            = (SCR1_DR_NUM > 1) ? $clog2(SCR1_DR_NUM) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SEL_W-1:0]                  dr_sel,
  input  logic                              fsm_dr_capture,
  input  logic                              fsm_dr_shift,
  input  logic                              fsm_dr_update,
  input  logic                              din_serial,
  input  logic [SCR1_DR_NUM*SCR1_WIDTH-1:0] din_parallel,
  output logic                              dout_serial,
  output logic [SCR1_DR_NUM*SCR1_WIDTH-1:0] dout_parallel,
  output logic [SCR1_DR_NUM-1:0]            dout_upd_vld,
  output logic                              dout_upd_err
);

  localparam int W     = SCR1_WIDTH;
  localparam int N     = SCR1_DR_NUM;
  localparam int CNT_W = $clog2(W + 2);

  logic [W-1:0]     shift_reg [N];
  logic [W-1:0]     upd_reg   [N];
  logic [CNT_W-1:0] shift_cnt;
  logic             seq_vld;
  logic [SEL_W-1:0] cap_sel;

  logic [N-1:0]     sel_hit;
  logic             sel_vld;
  logic             len_ok;
  logic             upd_acc;

  // Shift toward the LSB with TDI entering at the MSB; also covers W=1.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic bit_in);
    logic [W:0] tmp;
    tmp = {bit_in, cur};
    return tmp[W:1];
  endfunction

  // Select decode is widened by one bit so out-of-range codes never alias a channel.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      sel_hit[k] = ({1'b0, dr_sel} == (SEL_W+1)'(k));
    end
    sel_vld = |sel_hit;
  end

  always_comb begin
    dout_serial = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_hit[k]) dout_serial = shift_reg[k][0];
    end
  end

  assign len_ok  = seq_vld && (shift_cnt == CNT_W'(W)) && (dr_sel == cap_sel);
  assign upd_acc = !SCR1_STRICT_LEN || len_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        shift_reg[k] <= SCR1_RESET_VALUE;
        upd_reg[k]   <= SCR1_RESET_VALUE;
      end
      shift_cnt    <= '0;
      seq_vld      <= 1'b0;
      cap_sel      <= '0;
      dout_upd_vld <= '0;
      dout_upd_err <= 1'b0;
    end else begin
      dout_upd_vld <= '0;
      dout_upd_err <= 1'b0;
      if (sel_vld) begin
        if (fsm_dr_capture) begin
          for (int k = 0; k < N; k++) begin
            if (sel_hit[k]) shift_reg[k] <= din_parallel[k*W +: W];
          end
          cap_sel   <= dr_sel;
          shift_cnt <= '0;
          seq_vld   <= 1'b1;
        end else if (fsm_dr_shift) begin
          for (int k = 0; k < N; k++) begin
            if (sel_hit[k]) shift_reg[k] <= shift_in(shift_reg[k], din_serial);
          end
          if (dr_sel != cap_sel) seq_vld <= 1'b0;
          // Saturating at W+1 keeps over-length scans distinguishable from exact ones.
          if (shift_cnt != CNT_W'(W + 1)) shift_cnt <= shift_cnt + CNT_W'(1);
        end else if (fsm_dr_update) begin
          if (upd_acc) begin
            for (int k = 0; k < N; k++) begin
              if (sel_hit[k]) upd_reg[k] <= shift_reg[k];
            end
            dout_upd_vld <= sel_hit;
          end else begin
            dout_upd_err <= 1'b1;
          end
          seq_vld <= 1'b0;
        end
      end
    end
  end

  for (genvar gk = 0; gk < N; gk++) begin : g_dout
    assign dout_parallel[gk*W +: W] = upd_reg[gk];
  end

endmodule

// File: tb/tb_scr1_tapc_dr_bank.sv
// Bench for scr1_tapc_dr_bank: strict and relaxed 4x32 banks checked against a
// behavioural model, plus directed checks on a 1x1 bank.
module tb_scr1_tapc_dr_bank;

  localparam int          N  = 4;
  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cap, sh, upd, tdi;
  logic [1:0]    sel;
  logic [127:0]  din;
  logic          so_s, so_n, err_s, err_n;
  logic [127:0]  par_s, par_n;
  logic [3:0]    vld_s, vld_n;

  logic          t_rst_n, t_sel, t_cap, t_sh, t_upd, t_tdi;
  logic [0:0]    t_din, t_par, t_vld;
  logic          t_so, t_err;

  scr1_tapc_dr_bank #(.SCR1_DR_NUM(N), .SCR1_WIDTH(W), .SCR1_RESET_VALUE(RV), .SCR1_STRICT_LEN(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .dr_sel(sel), .fsm_dr_capture(cap), .fsm_dr_shift(sh),
    .fsm_dr_update(upd), .din_serial(tdi), .din_parallel(din), .dout_serial(so_s),
    .dout_parallel(par_s), .dout_upd_vld(vld_s), .dout_upd_err(err_s));

  scr1_tapc_dr_bank #(.SCR1_DR_NUM(N), .SCR1_WIDTH(W), .SCR1_RESET_VALUE(RV), .SCR1_STRICT_LEN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .dr_sel(sel), .fsm_dr_capture(cap), .fsm_dr_shift(sh),
    .fsm_dr_update(upd), .din_serial(tdi), .din_parallel(din), .dout_serial(so_n),
    .dout_parallel(par_n), .dout_upd_vld(vld_n), .dout_upd_err(err_n));

  scr1_tapc_dr_bank #(.SCR1_DR_NUM(1), .SCR1_WIDTH(1), .SCR1_RESET_VALUE(1'b0), .SCR1_STRICT_LEN(1'b1)) dut_t (
    .clk(clk), .rst_n(t_rst_n), .dr_sel(t_sel), .fsm_dr_capture(t_cap), .fsm_dr_shift(t_sh),
    .fsm_dr_update(t_upd), .din_serial(t_tdi), .din_parallel(t_din), .dout_serial(t_so),
    .dout_parallel(t_par), .dout_upd_vld(t_vld), .dout_upd_err(t_err));

  int checks   = 0;
  int failures = 0;

  // Model: index 0 = strict bank, index 1 = relaxed bank.
  logic [31:0] m_sreg [2][4];
  logic [31:0] m_ureg [2][4];
  int          m_cnt  [2];
  bit          m_seq  [2];
  int          m_cap  [2];
  logic [3:0]  e_vld  [2];
  logic        e_err  [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_ureg(input int i);
    logic [127:0] r;
    for (int k = 0; k < N; k++) r[k*32 +: 32] = m_ureg[i][k];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) begin
        m_sreg[i][k] = RV;
        m_ureg[i][k] = RV;
      end
      m_cnt[i] = 0; m_seq[i] = 0; m_cap[i] = 0; e_vld[i] = '0; e_err[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i);
    int s;
    s = int'(sel);
    e_vld[i] = '0;
    e_err[i] = 1'b0;
    if (s < N) begin
      if (cap) begin
        m_sreg[i][s] = din[s*32 +: 32];
        m_cap[i] = s; m_cnt[i] = 0; m_seq[i] = 1;
      end else if (sh) begin
        m_sreg[i][s] = {tdi, m_sreg[i][s][31:1]};
        if (s != m_cap[i]) m_seq[i] = 0;
        if (m_cnt[i] < W + 1) m_cnt[i]++;
      end else if (upd) begin
        if (i == 1 || (m_seq[i] && m_cnt[i] == W && s == m_cap[i])) begin
          m_ureg[i][s] = m_sreg[i][s];
          e_vld[i] = 4'(1 << s);
        end else begin
          e_err[i] = 1'b1;
        end
        m_seq[i] = 0;
      end
    end
  endtask

  task automatic step(input logic [1:0] s, input logic c, input logic h, input logic u, input logic t);
    sel = s; cap = c; sh = h; upd = u; tdi = t;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    chk("strict_par", par_s, pack_ureg(0));
    chk("strict_vld", 128'(vld_s), 128'(e_vld[0]));
    chk("strict_err", 128'(err_s), 128'(e_err[0]));
    chk("strict_so", 128'(so_s), 128'(m_sreg[0][s][0]));
    chk("relax_par", par_n, pack_ureg(1));
    chk("relax_vld", 128'(vld_n), 128'(e_vld[1]));
    chk("relax_err", 128'(err_n), 128'(e_err[1]));
    chk("relax_so", 128'(so_n), 128'(m_sreg[1][s][0]));
  endtask

  task automatic tstep(input logic s, input logic c, input logic h, input logic u, input logic t,
                       input logic ep, input logic ev, input logic ee, input logic es);
    t_sel = s; t_cap = c; t_sh = h; t_upd = u; t_tdi = t;
    @(posedge clk);
    #1;
    chk("tiny_par", 128'(t_par), 128'(ep));
    chk("tiny_vld", 128'(t_vld), 128'(ev));
    chk("tiny_err", 128'(t_err), 128'(ee));
    chk("tiny_so", 128'(t_so), 128'(es));
  endtask

  task automatic rand_din();
    din = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [31:0] pat, got;
    int ch, n;

    rst_n = 1'b0; sel = '0; cap = 0; sh = 0; upd = 0; tdi = 0; din = '0;
    t_rst_n = 1'b0; t_sel = 0; t_cap = 0; t_sh = 0; t_upd = 0; t_tdi = 0; t_din = 1'b1;
    model_reset();

    // Reset overrides every strobe.
    rand_din();
    step(2'd1, 1, 1, 1, 1);
    step(2'd0, 1, 0, 1, 0);
    rst_n = 1'b1;
    chk("reset_par", par_s, {4{RV}});
    chk("reset_so", 128'(so_s), 128'(1'b1));
    chk("reset_pulses", 128'({vld_s, err_s, vld_n, err_n}), 128'(0));

    // Basic sequence on channel 2.
    rand_din();
    din[64 +: 32] = 32'h1234_5678;
    pat = 32'hDEAD_BEEF;
    step(2'd2, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      got[i] = so_s;
      step(2'd2, 0, 1, 0, pat[i]);
    end
    chk("basic_serial_out", 128'(got), 128'(32'h1234_5678));
    step(2'd2, 0, 0, 1, 0);
    chk("basic_vld", 128'(vld_s), 128'(4'b0100));
    chk("basic_slice", 128'(par_s[64 +: 32]), 128'(32'hDEAD_BEEF));
    step(2'd2, 0, 0, 0, 0);
    chk("basic_vld_one_cycle", 128'(vld_s), 128'(0));

    // Short and long scans on channel 1.
    for (int r = 0; r < 2; r++) begin
      rand_din();
      step(2'd1, 1, 0, 0, 0);
      for (int i = 0; i < (r == 0 ? 31 : 33); i++) step(2'd1, 0, 1, 0, 1'($urandom));
      step(2'd1, 0, 0, 1, 0);
      chk("len_err_strict", 128'({err_s, vld_s}), 128'(5'b10000));
      chk("len_slice_unchanged", 128'(par_s[32 +: 32]), 128'(RV));
      chk("len_relaxed_vld", 128'({err_n, vld_n}), 128'(5'b00010));
    end

    // Select change mid-sequence.
    rand_din();
    step(2'd0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(2'd0, 0, 1, 0, 1'($urandom));
    for (int i = 0; i < 16; i++) step(2'd1, 0, 1, 0, 1'($urandom));
    step(2'd1, 0, 0, 1, 0);
    chk("selchg_err", 128'({err_s, vld_s}), 128'(5'b10000));

    // Overlapping strobes act as capture only.
    rand_din();
    step(2'd3, 1, 1, 1, 1);
    chk("overlap_no_pulse", 128'({err_s, vld_s, err_n, vld_n}), 128'(0));
    chk("overlap_captured_lsb", 128'(so_s), 128'(din[96]));

    // Reset mid-shift, then update without fresh capture.
    rand_din();
    step(2'd1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(2'd1, 0, 1, 0, 1'($urandom));
    rst_n = 1'b0;
    step(2'd1, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(2'd1, 0, 0, 1, 0);
    chk("rst_mid_err", 128'(err_s), 128'(1'b1));
    chk("rst_mid_par", par_s, {4{RV}});

    // Randomised scans: mostly exact length, some short/long, select glitches, overlaps.
    for (int r = 0; r < 60; r++) begin
      ch = int'($urandom_range(0, 3));
      rand_din();
      step(2'(ch), 1, 0, 0, 0);
      n = ($urandom_range(0, 1) == 1) ? 32 : int'($urandom_range(30, 34));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 63) == 0) step(2'($urandom), 0, 1, 0, 1'($urandom));
        else step(2'(ch), 0, 1, 0, 1'($urandom));
      end
      step(2'(ch), 1'($urandom_range(0, 7) == 0), 0, 1, 0);
      for (int i = 0; i < 2; i++) begin
        rand_din();
        step(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    // 1-channel, 1-bit bank.
    tstep(0, 1, 1, 1, 1, 0, 0, 0, 0);
    t_rst_n = 1'b1;
    tstep(0, 1, 0, 0, 0, 0, 0, 0, 1);
    tstep(0, 0, 1, 0, 1, 0, 0, 0, 1);
    tstep(0, 0, 0, 1, 0, 1, 1, 0, 1);
    tstep(0, 1, 0, 0, 0, 1, 0, 0, 1);
    tstep(0, 0, 1, 0, 0, 1, 0, 0, 0);
    tstep(0, 0, 0, 1, 0, 0, 1, 0, 0);
    tstep(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tstep(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tstep(1, 0, 1, 0, 1, 0, 0, 0, 0);
    tstep(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tstep(1, 0, 0, 1, 0, 0, 0, 0, 0);
    tstep(0, 0, 0, 1, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
